// File: rtl/mcp300x_pkg.sv
// mcp300x_pkg: shared state encoding, defaults and helpers for the MCP300x scanner
package mcp300x_pkg;
  localparam int NUM_CH      = 8;
  localparam int DEF_DIVIDER = 12;
  localparam int DEF_TIMEOUT = 4095;
  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_CONVERT,
    S_STORE,
    S_DONE
  } state_t;
  function automatic logic [2:0] lowest_ch(input logic [NUM_CH-1:0] m);
    lowest_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i]) lowest_ch = 3'(i);
  endfunction
endpackage

// File: rtl/mcp300x_result_bank.sv
// mcp300x_result_bank: 8x10 result registers, one write port, one registered read port
module mcp300x_result_bank
  import mcp300x_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       we_i,
  input  logic [2:0] wr_addr_i,
  input  logic [9:0] wr_data_i,
  input  logic [2:0] rd_addr_i,
  output logic [9:0] rd_data_o
);
  logic [9:0] r_mem [NUM_CH];
  // the read samples the array before this edge's write lands
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_mem     <= '{default: '0};
      rd_data_o <= '0;
    end else begin
      rd_data_o <= r_mem[rd_addr_i];
      if (we_i) r_mem[wr_addr_i] <= wr_data_i;
    end
  end
endmodule

// File: rtl/mcp300x_scanner.sv
// mcp300x_scanner: sequences masked channel conversions through an external MCP300x
// SPI master and keeps the latest result per channel.
module mcp300x_scanner
  import mcp300x_pkg::*;
#(
  parameter int DIVIDER = DEF_DIVIDER,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       run_i,
  input  logic       oneshot_i,
  input  logic [7:0] mask_i,
  input  logic       diff_i,
  output logic       ad_ena_o,
  output logic       ad_start_o,
  output logic [2:0] ad_chn_o,
  output logic       ad_single_o,
  input  logic       ad_eoc_i,
  input  logic [9:0] ad_data_i,
  input  logic [2:0] rd_addr_i,
  output logic [9:0] rd_data_o,
  output logic [7:0] valid_o,
  output logic       busy_o,
  output logic       scan_done_o,
  output logic       timeout_o
);
  state_t      r_state, w_next;
  logic [7:0]  r_div, r_pend, r_valid;
  logic [15:0] r_wdog;
  logic [2:0]  r_chn, w_sel;
  logic [9:0]  r_data;
  logic        r_single, r_timeout, w_scan_start, w_tmo;

  assign w_sel        = lowest_ch(r_pend);
  assign w_scan_start = |mask_i && ((r_state == S_IDLE && (run_i || oneshot_i)) ||
                                    (r_state == S_DONE && run_i));
  // an eoc on the final watchdog cycle still wins over the abort
  assign w_tmo        = r_state == S_CONVERT && !ad_eoc_i && r_wdog == 16'(TIMEOUT - 1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = w_scan_start ? S_SELECT : S_IDLE;
      S_SELECT:  w_next = S_CONVERT;
      S_CONVERT: w_next = ad_eoc_i ? S_STORE : w_tmo ? (|r_pend ? S_SELECT : S_DONE) : S_CONVERT;
      S_STORE:   w_next = |r_pend ? S_SELECT : S_DONE;
      S_DONE:    w_next = w_scan_start ? S_SELECT : S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_wdog    <= '0;
      r_pend    <= '0;
      r_valid   <= '0;
      r_chn     <= '0;
      r_data    <= '0;
      r_single  <= 1'b1;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      r_div   <= ad_ena_o ? '0 : r_div + 8'd1;
      if (w_scan_start) begin
        r_pend    <= mask_i;
        r_single  <= ~diff_i;
        r_timeout <= 1'b0;
      end
      if (r_state == S_SELECT) begin
        r_chn  <= w_sel;
        r_pend <= r_pend & ~(8'd1 << w_sel);
        r_wdog <= '0;
      end
      if (r_state == S_CONVERT) r_wdog <= r_wdog + 16'd1;
      if (r_state == S_CONVERT && ad_eoc_i) r_data <= ad_data_i;
      if (w_tmo) r_timeout <= 1'b1;
      if (r_state == S_STORE) r_valid[r_chn] <= 1'b1;
    end
  end

  assign ad_ena_o    = r_div == 8'(DIVIDER - 1);
  assign ad_start_o  = r_state == S_CONVERT;
  assign ad_chn_o    = r_chn;
  assign ad_single_o = r_single;
  assign valid_o     = r_valid;
  assign busy_o      = r_state != S_IDLE;
  assign scan_done_o = r_state == S_DONE;
  assign timeout_o   = r_timeout;

  mcp300x_result_bank u_bank (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .we_i      (r_state == S_STORE),
    .wr_addr_i (r_chn),
    .wr_data_i (r_data),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (rd_data_o)
  );
endmodule

// File: tb/tb_mcp300x_scanner.sv
// tb_mcp300x_scanner: table-driven and randomized scans against a channel-level reference model
module tb_mcp300x_scanner;
  localparam int DIV = 12;
  localparam int TMO = 100;

  logic       clk_i = 0, rst_n_i = 0, run_i = 0, oneshot_i = 0, diff_i = 0, ad_eoc_i = 0;
  logic [7:0] mask_i = '0;
  logic [9:0] ad_data_i = '0;
  logic [2:0] rd_addr_i = '0;
  logic       ad_ena_o, ad_start_o, ad_single_o, busy_o, scan_done_o, timeout_o;
  logic [2:0] ad_chn_o;
  logic [9:0] rd_data_o;
  logic [7:0] valid_o;

  mcp300x_scanner #(.DIVIDER(DIV), .TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .run_i(run_i), .oneshot_i(oneshot_i),
    .mask_i(mask_i), .diff_i(diff_i), .ad_ena_o(ad_ena_o), .ad_start_o(ad_start_o),
    .ad_chn_o(ad_chn_o), .ad_single_o(ad_single_o), .ad_eoc_i(ad_eoc_i),
    .ad_data_i(ad_data_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
    .valid_o(valid_o), .busy_o(busy_o), .scan_done_o(scan_done_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int errs = 0, checks = 0;
  int log_ch[$], log_sg[$], log_len[$];
  int done_cnt = 0, run_len = 0, chn_unstable = 0;
  logic prev_start = 0;
  logic [2:0] cur_chn = '0;
  bit resp_en = 1;
  int max_delay = 20;
  logic [7:0] silent = '0;
  logic [9:0] data_by_ch [8];
  logic [9:0] exp_bank [8];
  logic [7:0] exp_valid = '0;

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // conversion monitor: one log entry per ad_start_o burst
  always @(negedge clk_i) begin
    if (ad_start_o && !prev_start) begin
      log_ch.push_back(int'(ad_chn_o));
      log_sg.push_back(int'(ad_single_o));
      cur_chn = ad_chn_o;
      run_len = 0;
    end
    if (ad_start_o) begin
      run_len++;
      if (ad_chn_o !== cur_chn) chn_unstable++;
    end
    if (!ad_start_o && prev_start) log_len.push_back(run_len);
    if (scan_done_o) done_cnt++;
    prev_start = ad_start_o;
  end

  // MCP300x stand-in: answers after a random delay unless the channel is silent
  initial begin : responder
    int ch;
    forever begin
      tick();
      if (resp_en && ad_start_o) begin
        ch = int'(ad_chn_o);
        if (!silent[ch]) begin
          repeat ($urandom_range(max_delay)) tick();
          ad_data_i = data_by_ch[ch];
          ad_eoc_i  = 1;
          tick();
          ad_eoc_i  = 0;
          ad_data_i = 10'($urandom);
        end
        for (int k = 0; k < 1000 && ad_start_o; k++) tick();
      end
    end
  end

  task automatic do_reset();
    rst_n_i = 0; run_i = 0; oneshot_i = 0; ad_eoc_i = 0;
    tick(); tick();
    rst_n_i = 1;
    tick();
    exp_valid = '0;
    for (int i = 0; i < 8; i++) exp_bank[i] = '0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < 5000) begin tick(); n++; end
    if (done_cnt == d0) begin
      checks++; errs++;
      $display("FAIL %s: no scan_done_o within %0d cycles", name, n);
    end
  endtask

  task automatic read_bank(input string name);
    for (int i = 0; i < 8; i++) begin
      rd_addr_i = 3'(i);
      tick();
      chk($sformatf("%s bank[%0d]", name, i), 32'(rd_data_o), 32'(exp_bank[i]));
    end
  endtask

  // one oneshot scan; order and bank contents come from the channel-level model
  task automatic run_check(input string name, input logic [7:0] m, input logic d,
                           input logic [7:0] s, input logic [7:0] ev, input logic et);
    int exp_ch[$];
    int d0;
    silent = s;
    log_ch.delete(); log_sg.delete(); log_len.delete(); chn_unstable = 0;
    d0 = done_cnt;
    mask_i = m; diff_i = d; oneshot_i = 1;
    tick();
    oneshot_i = 0; mask_i = 8'($urandom); diff_i = 1'($urandom);
    wait_done(name);
    for (int i = 0; i < 8; i++)
      if (m[i]) begin
        exp_ch.push_back(i);
        if (!s[i]) exp_bank[i] = data_by_ch[i];
      end
    chk({name, " n_conv"}, 32'(log_ch.size()), 32'(exp_ch.size()));
    foreach (exp_ch[k])
      if (k < log_ch.size()) begin
        chk($sformatf("%s order[%0d]", name, k), 32'(log_ch[k]), 32'(exp_ch[k]));
        chk($sformatf("%s single[%0d]", name, k), 32'(log_sg[k]), 32'(!d));
        if (s[exp_ch[k]] && k < log_len.size())
          chk($sformatf("%s tmo_len[%0d]", name, k), 32'(log_len[k]), 32'(TMO));
      end
    chk({name, " timeout"}, 32'(timeout_o), 32'(et));
    chk({name, " valid"}, 32'(valid_o), 32'(ev));
    chk({name, " chn_stable"}, 32'(chn_unstable), 0);
    read_bank(name);
    chk({name, " done_pulses"}, 32'(done_cnt - d0), 1);
    chk({name, " idle"}, 32'(busy_o), 0);
  endtask

  typedef struct {
    logic [7:0] mask;
    logic       diff;
    logic [7:0] silent;
    logic [7:0] exp_valid;
    logic       exp_to;
  } vec_t;
  vec_t tab[5];

  initial begin
    int gap, n, busy_seen, d0;
    logic [7:0] m, s;
    logic d;
    tab[0] = '{8'h05, 1'b0, 8'h00, 8'h05, 1'b0};
    tab[1] = '{8'h03, 1'b0, 8'h01, 8'h02, 1'b1};
    tab[2] = '{8'h80, 1'b1, 8'h00, 8'h80, 1'b0};
    tab[3] = '{8'hFF, 1'b0, 8'h00, 8'hFF, 1'b0};
    tab[4] = '{8'h24, 1'b1, 8'h20, 8'h04, 1'b1};
    data_by_ch = '{10'h155, 10'h2A1, 10'h0AA, 10'h3C3, 10'h10F, 10'h2F0, 10'h077, 10'h388};

    // reset values while held in reset
    tick();
    chk("rst ena", 32'(ad_ena_o), 0);
    chk("rst start", 32'(ad_start_o), 0);
    chk("rst chn", 32'(ad_chn_o), 0);
    chk("rst single", 32'(ad_single_o), 1);
    chk("rst valid", 32'(valid_o), 0);
    chk("rst busy", 32'(busy_o), 0);
    chk("rst done", 32'(scan_done_o), 0);
    chk("rst timeout", 32'(timeout_o), 0);
    chk("rst rd_data", 32'(rd_data_o), 0);
    do_reset();

    // bit-rate enable period and width
    n = 0;
    while (!ad_ena_o && n < 50) begin tick(); n++; end
    chk("ena seen", 32'(ad_ena_o), 1);
    for (int r = 0; r < 3; r++) begin
      tick();
      chk($sformatf("ena width %0d", r), 32'(ad_ena_o), 0);
      gap = 1;
      while (!ad_ena_o && gap < 50) begin tick(); gap++; end
      chk($sformatf("ena period %0d", r), 32'(gap), DIV);
    end

    foreach (tab[t]) begin
      do_reset();
      run_check($sformatf("tab%0d", t), tab[t].mask, tab[t].diff, tab[t].silent,
                tab[t].exp_valid, tab[t].exp_to);
    end

    // oneshot while busy is ignored; registered read latency
    do_reset();
    silent = '0;
    log_ch.delete();
    d0 = done_cnt;
    mask_i = 8'h01; oneshot_i = 1; tick(); oneshot_i = 0;
    tick(); tick();
    mask_i = 8'h02; oneshot_i = 1; tick(); oneshot_i = 0;
    wait_done("ignore_oneshot");
    repeat (5) tick();
    chk("ignore_oneshot n_conv", 32'(log_ch.size()), 1);
    chk("ignore_oneshot valid", 32'(valid_o), 32'h01);
    chk("ignore_oneshot done", 32'(done_cnt - d0), 1);
    rd_addr_i = 0; tick();
    chk("rd ch0", 32'(rd_data_o), 32'h155);
    rd_addr_i = 1; #1;
    chk("rd registered", 32'(rd_data_o), 32'h155);
    tick();
    chk("rd ch1 empty", 32'(rd_data_o), 0);

    // mask zero never starts; eoc in IDLE is ignored
    do_reset();
    log_ch.delete();
    mask_i = 8'h00; run_i = 1; oneshot_i = 1; busy_seen = 0;
    tick(); oneshot_i = 0;
    repeat (20) begin tick(); if (busy_o) busy_seen++; end
    run_i = 0;
    chk("mask0 busy", 32'(busy_seen), 0);
    ad_data_i = 10'h3FF; ad_eoc_i = 1; tick(); ad_eoc_i = 0; tick();
    chk("idle eoc valid", 32'(valid_o), 0);
    chk("idle eoc busy", 32'(busy_o), 0);

    // continuous run on ch7, then drop run_i mid-conversion
    do_reset();
    silent = '0;
    log_ch.delete();
    data_by_ch[7] = 10'h1E7;
    mask_i = 8'h80; run_i = 1;
    repeat (3) wait_done("run");
    n = 0;
    while (!ad_start_o && n < 200) begin tick(); n++; end
    chk("run in convert", 32'(ad_start_o), 1);
    run_i = 0;
    gap = log_ch.size();
    wait_done("run_stop");
    repeat (6) tick();
    chk("run_stop idle", 32'(busy_o), 0);
    chk("run_stop no new conv", 32'(log_ch.size()), 32'(gap));
    chk("run_stop conv count", 32'(gap >= 4), 1);
    foreach (log_ch[k]) chk($sformatf("run ch[%0d]", k), 32'(log_ch[k]), 7);
    chk("run valid", 32'(valid_o), 32'h80);
    rd_addr_i = 7; tick();
    chk("run bank7", 32'(rd_data_o), 32'h1E7);

    // reset while converting with eoc on the same edge
    do_reset();
    resp_en = 0;
    mask_i = 8'h01; diff_i = 1; oneshot_i = 1; tick(); oneshot_i = 0;
    n = 0;
    while (!ad_start_o && n < 20) begin tick(); n++; end
    tick();
    chk("diff single", 32'(ad_single_o), 0);
    ad_data_i = 10'h3FF; ad_eoc_i = 1; rst_n_i = 0; #1;
    chk("arst start", 32'(ad_start_o), 0);
    chk("arst single", 32'(ad_single_o), 1);
    chk("arst busy", 32'(busy_o), 0);
    chk("arst valid", 32'(valid_o), 0);
    chk("arst timeout", 32'(timeout_o), 0);
    chk("arst ena", 32'(ad_ena_o), 0);
    tick();
    ad_eoc_i = 0; rst_n_i = 1; resp_en = 1;
    tick(); tick();
    chk("arst stays idle", 32'(busy_o), 0);
    for (int i = 0; i < 8; i++) exp_bank[i] = '0;
    read_bank("arst");

    // random scans without reset: valid accumulates, timeout follows each scan
    do_reset();
    for (int r = 0; r < 12; r++) begin
      m = 8'($urandom_range(1, 255));
      d = 1'($urandom);
      s = m & 8'($urandom) & 8'($urandom) & 8'($urandom);
      for (int i = 0; i < 8; i++) data_by_ch[i] = 10'($urandom);
      exp_valid = exp_valid | (m & ~s);
      run_check($sformatf("rnd%0d", r), m, d, s, exp_valid, |s);
    end
    exp_valid = exp_valid | 8'h01;
    run_check("to_set", 8'h08, 1'b0, 8'h08, exp_valid, 1'b1);
    run_check("to_clear", 8'h01, 1'b0, 8'h00, exp_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
